// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data memory arbiter: FSM encoding and
// parameter defaults.
package dmem_arbiter_pkg;

   localparam int unsigned DefaultDepth    = 100;
   localparam int unsigned DefaultMaxBurst = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StOwn0 = 2'd1,
      StOwn1 = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: round-robin on ties,
// bounded bursts under contention, registered read/err responses per port.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH     = DefaultDepth,
   parameter int unsigned MAX_BURST = DefaultMaxBurst
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] mem_A,
   output logic [31:0] mem_WD,
   output logic        mem_WE,
   input  logic [31:0] mem_RD
);

   localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST - 1);

   state_e          r_state;
   state_e          w_state_d;
   logic            r_last_owner;
   logic            w_last_owner_d;
   logic [CntW-1:0] r_burst_cnt;
   logic [CntW-1:0] w_burst_cnt_d;

   logic            w_gnt0;
   logic            w_gnt1;
   logic            w_acc0;
   logic            w_acc1;
   logic            w_in_range0;
   logic            w_in_range1;

   logic            r_rvalid0;
   logic            r_rvalid1;
   logic            r_err0;
   logic            r_err1;
   logic [31:0]     r_rdata0;
   logic [31:0]     r_rdata1;

   // Grants decode from state only, so an async reset drops them immediately.
   assign w_gnt0      = (r_state == StOwn0);
   assign w_gnt1      = (r_state == StOwn1);
   assign w_acc0      = w_gnt0 & req0;
   assign w_acc1      = w_gnt1 & req1;
   assign w_in_range0 = (addr0 < 32'(DEPTH));
   assign w_in_range1 = (addr1 < 32'(DEPTH));

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         r_state      <= StIdle;
         r_last_owner <= 1'b1;
         r_burst_cnt  <= '0;
      end else begin
         r_state      <= w_state_d;
         r_last_owner <= w_last_owner_d;
         r_burst_cnt  <= w_burst_cnt_d;
      end
   end

   always_comb begin
      w_state_d      = r_state;
      w_last_owner_d = r_last_owner;
      w_burst_cnt_d  = r_burst_cnt;
      unique case (r_state)
         StIdle: begin
            if (req0 && req1) begin
               w_state_d = r_last_owner ? StOwn0 : StOwn1;
            end else if (req0) begin
               w_state_d = StOwn0;
            end else if (req1) begin
               w_state_d = StOwn1;
            end
         end
         StOwn0: begin
            if (!req0) begin
               w_last_owner_d = 1'b0;
               w_state_d      = req1 ? StOwn1 : StIdle;
            end else if (req1 && (r_burst_cnt == CntMax)) begin
               w_last_owner_d = 1'b0;
               w_state_d      = StOwn1;
            end else if (r_burst_cnt != CntMax) begin
               w_burst_cnt_d = r_burst_cnt + 1'b1;
            end
         end
         StOwn1: begin
            if (!req1) begin
               w_last_owner_d = 1'b1;
               w_state_d      = req0 ? StOwn0 : StIdle;
            end else if (req0 && (r_burst_cnt == CntMax)) begin
               w_last_owner_d = 1'b1;
               w_state_d      = StOwn0;
            end else if (r_burst_cnt != CntMax) begin
               w_burst_cnt_d = r_burst_cnt + 1'b1;
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
      // Every ownership change starts a fresh burst.
      if (w_state_d != r_state) begin
         w_burst_cnt_d = '0;
      end
   end

   always_comb begin
      mem_A  = '0;
      mem_WD = '0;
      if (w_gnt0) begin
         mem_A  = addr0;
         mem_WD = wdata0;
      end else if (w_gnt1) begin
         mem_A  = addr1;
         mem_WD = wdata1;
      end
   end

   assign mem_WE = (w_acc0 & we0 & w_in_range0) | (w_acc1 & we1 & w_in_range1);

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_err0    <= 1'b0;
         r_err1    <= 1'b0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
      end else begin
         r_rvalid0 <= w_acc0 & ~we0 & w_in_range0;
         r_rvalid1 <= w_acc1 & ~we1 & w_in_range1;
         r_err0    <= w_acc0 & ~w_in_range0;
         r_err1    <= w_acc1 & ~w_in_range1;
         if (w_acc0 && !w_in_range0) begin
            r_rdata0 <= '0;
         end else if (w_acc0 && !we0) begin
            r_rdata0 <= mem_RD;
         end
         if (w_acc1 && !w_in_range1) begin
            r_rdata1 <= '0;
         end else if (w_acc1 && !we1) begin
            r_rdata1 <= mem_RD;
         end
      end
   end

   assign gnt0    = w_gnt0;
   assign gnt1    = w_gnt1;
   assign rvalid0 = r_rvalid0;
   assign rvalid1 = r_rvalid1;
   assign err0    = r_err0;
   assign err1    = r_err1;
   assign rdata0  = r_rdata0;
   assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle vector table with a response
// scoreboard, plus directed burst, reset-abort and single-requester sequences.
module tb_dmem_arbiter;

   localparam int unsigned DEPTH     = 100;
   localparam int unsigned MAX_BURST = 4;

   logic        CLK;
   logic        rst;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] mem_A, mem_WD, mem_RD;
   logic        mem_WE;

   int n_checks = 0;
   int n_errors = 0;

   dmem_arbiter #(
      .DEPTH     (DEPTH),
      .MAX_BURST (MAX_BURST)
   ) u_dut (
      .CLK     (CLK),
      .rst     (rst),
      .req0    (req0),
      .req1    (req1),
      .we0     (we0),
      .we1     (we1),
      .addr0   (addr0),
      .addr1   (addr1),
      .wdata0  (wdata0),
      .wdata1  (wdata1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .rvalid0 (rvalid0),
      .rvalid1 (rvalid1),
      .rdata0  (rdata0),
      .rdata1  (rdata1),
      .err0    (err0),
      .err1    (err1),
      .mem_A   (mem_A),
      .mem_WD  (mem_WD),
      .mem_WE  (mem_WE),
      .mem_RD  (mem_RD)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Attached memory: combinational read, write on the rising edge.
   logic [31:0] mem [0:127];
   assign mem_RD = (mem_A < 32'd128) ? mem[mem_A[6:0]] : 32'h0;
   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
      forever begin
         @(posedge CLK);
         if (mem_WE) mem[mem_A[6:0]] = mem_WD;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   typedef struct packed {
      logic        r0, w0;
      logic [31:0] a0, d0;
      logic        r1, w1;
      logic [31:0] a1, d1;
      logic        g0, g1, we;
   } vec_t;

   typedef struct packed {
      logic        rv0, er0;
      logic [31:0] rd0;
      logic        rv1, er1;
      logic [31:0] rd1;
   } resp_t;

   vec_t        vt [25];
   resp_t       sb [$];
   logic [31:0] model_mem [0:127];
   logic [31:0] exp_rd0, exp_rd1;

   function automatic vec_t mk(input logic r0, input logic w0, input logic [31:0] a0,
                               input logic [31:0] d0, input logic r1, input logic w1,
                               input logic [31:0] a1, input logic [31:0] d1,
                               input logic g0, input logic g1, input logic we);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1; v.we = we;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic r1, input logic w1,
                        input logic [31:0] a1, input logic [31:0] d1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
   endtask

   // Asserts reset, checks the reset outputs, returns at a falling edge with rst high.
   task automatic reset_dut();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge CLK);
      #1;
      chk("rst gnt0", 32'(gnt0), 0);
      chk("rst gnt1", 32'(gnt1), 0);
      chk("rst mem_WE", 32'(mem_WE), 0);
      chk("rst mem_A", mem_A, 0);
      chk("rst rvalid", {30'd0, rvalid0, rvalid1}, 0);
      chk("rst err", {30'd0, err0, err1}, 0);
      chk("rst rdata0", rdata0, 0);
      chk("rst rdata1", rdata1, 0);
      exp_rd0 = '0;
      exp_rd1 = '0;
      sb.delete();
      @(negedge CLK);
      rst = 1'b1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      resp_t       e;
      logic        acc0, acc1, in0, in1;
      logic [31:0] ea;
      drive(v.r0, v.w0, v.a0, v.d0, v.r1, v.w1, v.a1, v.d1);
      #1;
      ea = v.g0 ? v.a0 : (v.g1 ? v.a1 : 32'h0);
      chk($sformatf("vec%0d gnt0", idx), 32'(gnt0), 32'(v.g0));
      chk($sformatf("vec%0d gnt1", idx), 32'(gnt1), 32'(v.g1));
      chk($sformatf("vec%0d mem_WE", idx), 32'(mem_WE), 32'(v.we));
      chk($sformatf("vec%0d mem_A", idx), mem_A, ea);
      acc0 = v.g0 & v.r0;
      acc1 = v.g1 & v.r1;
      in0  = (v.a0 < 32'(DEPTH));
      in1  = (v.a1 < 32'(DEPTH));
      e = '0;
      if (acc0 && !in0) begin
         e.er0 = 1'b1; exp_rd0 = '0;
      end else if (acc0 && !v.w0) begin
         e.rv0 = 1'b1; exp_rd0 = model_mem[v.a0[6:0]];
      end
      if (acc1 && !in1) begin
         e.er1 = 1'b1; exp_rd1 = '0;
      end else if (acc1 && !v.w1) begin
         e.rv1 = 1'b1; exp_rd1 = model_mem[v.a1[6:0]];
      end
      if (acc0 && v.w0 && in0) model_mem[v.a0[6:0]] = v.d0;
      if (acc1 && v.w1 && in1) model_mem[v.a1[6:0]] = v.d1;
      e.rd0 = exp_rd0;
      e.rd1 = exp_rd1;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      if (sb.size() == 0) begin
         chk($sformatf("vec%0d scoreboard empty", idx), 1, 0);
      end else begin
         e = sb.pop_front();
         chk($sformatf("vec%0d rvalid0", idx), 32'(rvalid0), 32'(e.rv0));
         chk($sformatf("vec%0d err0", idx), 32'(err0), 32'(e.er0));
         chk($sformatf("vec%0d rdata0", idx), rdata0, e.rd0);
         chk($sformatf("vec%0d rvalid1", idx), 32'(rvalid1), 32'(e.rv1));
         chk($sformatf("vec%0d err1", idx), 32'(err1), 32'(e.er1));
         chk($sformatf("vec%0d rdata1", idx), rdata1, e.rd1);
      end
      @(negedge CLK);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) model_mem[i] = 32'hC0DE_0000 + 32'(i);
      //            r0 w0 a0   d0            r1 w1 a1   d1            g0 g1 we
      vt[0]  = mk(1, 1, 5,   32'h0000_ABCD, 0, 0, 0,   0,            0, 0, 0);
      vt[1]  = mk(1, 1, 5,   32'h0000_ABCD, 0, 0, 0,   0,            1, 0, 1);
      vt[2]  = mk(1, 0, 5,   0,             0, 0, 0,   0,            1, 0, 0);
      vt[3]  = mk(0, 0, 0,   0,             0, 0, 0,   0,            1, 0, 0);
      vt[4]  = mk(0, 0, 0,   0,             1, 1, 100, 32'hFFFF_FFFF, 0, 0, 0);
      vt[5]  = mk(0, 0, 0,   0,             1, 1, 100, 32'hFFFF_FFFF, 0, 1, 0);
      vt[6]  = mk(0, 0, 0,   0,             1, 0, 0,   0,            0, 1, 0);
      vt[7]  = mk(0, 0, 0,   0,             0, 0, 0,   0,            0, 1, 0);
      vt[8]  = mk(1, 0, 5,   0,             0, 0, 0,   0,            0, 0, 0);
      vt[9]  = mk(1, 0, 7,   0,             0, 0, 0,   0,            1, 0, 0);
      vt[10] = mk(0, 0, 0,   0,             1, 0, 99,  0,            1, 0, 0);
      vt[11] = mk(0, 0, 0,   0,             1, 0, 99,  0,            0, 1, 0);
      vt[12] = mk(0, 0, 0,   0,             0, 0, 0,   0,            0, 1, 0);
      vt[13] = mk(0, 0, 0,   0,             0, 0, 0,   0,            0, 0, 0);
      vt[14] = mk(1, 0, 100, 0,             0, 0, 0,   0,            0, 0, 0);
      vt[15] = mk(1, 0, 100, 0,             0, 0, 0,   0,            1, 0, 0);
      vt[16] = mk(1, 1, 99,  32'h1234_5678, 0, 0, 0,   0,            1, 0, 1);
      vt[17] = mk(1, 0, 99,  0,             0, 0, 0,   0,            1, 0, 0);
      vt[18] = mk(0, 0, 0,   0,             0, 0, 0,   0,            1, 0, 0);
      vt[19] = mk(1, 0, 1,   0,             1, 0, 2,   0,            0, 0, 0);
      vt[20] = mk(1, 0, 1,   0,             1, 0, 2,   0,            0, 1, 0);
      vt[21] = mk(1, 0, 1,   0,             0, 0, 0,   0,            0, 1, 0);
      vt[22] = mk(1, 0, 1,   0,             0, 0, 0,   0,            1, 0, 0);
      vt[23] = mk(0, 0, 0,   0,             0, 0, 0,   0,            1, 0, 0);
      vt[24] = mk(0, 0, 0,   0,             0, 0, 0,   0,            0, 0, 0);

      reset_dut();
      for (int i = 0; i < 25; i++) run_vec(i, vt[i]);

      // Continuous contention from reset release: 4-cycle bursts alternating.
      reset_dut();
      drive(1, 0, 1, 0, 1, 0, 2, 0);
      for (int c = 0; c < 25; c++) begin
         logic [1:0] eg;
         #1;
         if (c == 0) eg = 2'b00;
         else eg = ((((c - 1) / int'(MAX_BURST)) % 2) == 0) ? 2'b10 : 2'b01;
         chk($sformatf("burst cyc%0d {gnt0,gnt1}", c), {30'd0, gnt0, gnt1}, {30'd0, eg});
         @(negedge CLK);
      end

      // Reset asserted in the middle of a granted write aborts it.
      reset_dut();
      drive(1, 0, 4, 0, 0, 0, 0, 0);
      @(negedge CLK);
      @(negedge CLK);
      drive(1, 1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0);
      #1;
      chk("abort pre gnt0", 32'(gnt0), 1);
      chk("abort pre mem_WE", 32'(mem_WE), 1);
      chk("abort pre rdata0", rdata0, 32'hC0DE_0004);
      #1;
      rst = 1'b0;
      #1;
      chk("abort gnt0", 32'(gnt0), 0);
      chk("abort gnt1", 32'(gnt1), 0);
      chk("abort mem_WE", 32'(mem_WE), 0);
      chk("abort mem_A", mem_A, 0);
      chk("abort rdata0", rdata0, 0);
      chk("abort rvalid/err", {28'd0, rvalid0, rvalid1, err0, err1}, 0);
      @(negedge CLK);
      rst = 1'b1;
      drive(1, 0, 3, 0, 1, 0, 4, 0);
      #1;
      chk("post-rst idle {gnt0,gnt1}", {30'd0, gnt0, gnt1}, 0);
      @(negedge CLK);
      #1;
      chk("post-rst tie {gnt0,gnt1}", {30'd0, gnt0, gnt1}, 32'd2);
      @(posedge CLK);
      #1;
      chk("post-rst rvalid0", 32'(rvalid0), 1);
      chk("post-rst rdata0 (write aborted)", rdata0, 32'hC0DE_0003);
      @(negedge CLK);

      // Lone requester on port 1 keeps the grant past MAX_BURST.
      reset_dut();
      drive(0, 0, 0, 0, 1, 0, 9, 0);
      #1;
      chk("solo idle gnt1", 32'(gnt1), 0);
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         #1;
         chk($sformatf("solo cyc%0d {gnt0,gnt1}", c), {30'd0, gnt0, gnt1}, 32'd1);
      end
      @(negedge CLK);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 100: number of 32-bit words in the attached data memory.
REQ-002 Parameter MAX_BURST, default 4: maximum consecutive granted cycles for one port while the other port waits.
REQ-003 CLK  input  1: single clock; all state changes on the rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-low.
REQ-005 req0, req1  input  1 each: access request, port 0 (CPU) and port 1 (loader/debug).
REQ-006 we0, we1  input  1 each: 1 = write, 0 = read; qualified by reqN.
REQ-007 addr0, addr1  input  32 each: word address.
REQ-008 wdata0, wdata1  input  32 each: write data.
REQ-009 gnt0, gnt1  output  1 each: port owns the memory this cycle; never both high.
REQ-010 rvalid0, rvalid1  output  1 each: one-cycle pulse, registered read data valid.
REQ-011 rdata0, rdata1  output  32 each: registered read data.
REQ-012 err0, err1  output  1 each: one-cycle pulse, the previous granted access had addr >= DEPTH.
REQ-013 mem_A  output  32: memory address; mem_WD output 32: write data; mem_WE output 1: write enable.
REQ-014 mem_RD  input  32: combinational read data from memory.

Function
REQ-015 FSM states: IDLE, OWN0, OWN1; gntN = (state == OWNN), decoded from state only.
REQ-016 IDLE: only reqN -> OWNN; both -> port other than last_owner; neither -> stay IDLE.
REQ-017 Grant latency is exactly one cycle: req sampled high at edge k -> gnt high after edge k.
REQ-018 OWNN: reqN low at the edge -> OWN(other) if other req high, else IDLE; update last_owner = N.
REQ-019 OWNN with reqN high: burst_cnt increments per granted cycle; at burst_cnt == MAX_BURST-1 with other req high -> switch to OWN(other), burst_cnt = 0.
REQ-020 OWNN with reqN high and other req low: stay; burst_cnt saturates at MAX_BURST-1.
REQ-021 burst_cnt clears to 0 on every state change.
REQ-022 Access cycle = gntN & reqN; mem_A/mem_WD driven combinationally from the owner's addr/wdata; non-owned state drives mem_A = 0, mem_WD = 0.
REQ-023 mem_WE = gntN & reqN & weN & (addrN < DEPTH); out-of-range writes are dropped.
REQ-024 Read access in range: at the next edge rdataN <= mem_RD, rvalidN = 1 for one cycle.
REQ-025 Out-of-range access (read or write): at the next edge errN = 1 for one cycle, rdataN <= 0, rvalidN stays 0.
REQ-026 In-range write: no rvalid, no err.
REQ-027 rdataN holds its value until the next read completion on that port.
REQ-028 Requesters hold addr/we/wdata stable while reqN high; the arbiter does not latch them.
REQ-029 Simultaneous release of owner and request from other port in the same cycle: handover with no idle cycle.

Reset
REQ-030 rst low: state = IDLE, last_owner = 1 (port 0 wins first tie), burst_cnt = 0, rvalidN = 0, errN = 0, rdataN = 0.
REQ-031 Reset is asynchronous: gntN and mem_WE drop in the same cycle rst falls, aborting any access in progress.
REQ-032 First grant possible one cycle after the first rising edge with rst high.

Structure
REQ-033 Shared package holds the FSM state encoding (2 bits), the DEPTH default, and the MAX_BURST default.
REQ-034 No sub-module; single module, one FSM block, one registered response block, combinational memory mux.

Verification
REQ-035 Port 0 writes addr 5 data 0x0000_ABCD, then reads addr 5 -> gnt0 one cycle after req0; rvalid0 pulse with rdata0 = 0x0000_ABCD.
REQ-036 req0 and req1 high from reset release, continuous, MAX_BURST = 4 -> gnt0 for 4 cycles, gnt1 for 4 cycles, repeating; never both high.
REQ-037 Port 1 writes addr 100 data 0xFFFF_FFFF -> mem_WE stays 0, err1 pulses once; subsequent read of addr 0 returns the prior value.
REQ-038 Port 0 owner drops req0 in the cycle req1 rises -> gnt1 on the next cycle with no IDLE gap.
REQ-039 rst driven low mid-write (gnt0 high, we0 high) -> gnt0 and mem_WE low immediately; all outputs 0; after release, a tie grants port 0 first.
REQ-040 Single requester port 1 holding req1 for 10 cycles with req0 low -> gnt1 continuous for 10 cycles, no forced rotation.
